// File: rtl/bin_to_bcd_seq.sv
// Sequential binary to packed-BCD converter (shift-and-add-3). One conversion per
// accepted start; values above 10^D-1 saturate to all nines and raise ovf.
module bin_to_bcd_seq #(
    parameter int unsigned K = 16,
    parameter int unsigned W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic [K-1:0] bcd,
    output logic         valid,
    output logic         ovf
);

    localparam int unsigned D  = K / 4;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    function automatic logic [63:0] calc_maxv(input int unsigned digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < int'(digits); i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0]  MAXV  = calc_maxv(D);
    localparam logic [K-1:0] NINES = {D{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   bin_q, bin_d;
    logic [K-1:0]   work_q, work_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;
    logic [K-1:0]   bcd_q, bcd_d;

    logic [K-1:0]   work_adj;
    logic [K-1:0]   work_sh;
    logic [W-1:0]   bin_sh;

    // Digit correction: any work digit >= 5 gets +3 before the shift.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < int'(D); i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign work_sh = {work_adj[K-2:0], bin_q[W-1]};
    assign bin_sh  = {bin_q[W-2:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    bin_d      = bin;
                    work_d     = '0;
                    cnt_d      = CW'(W - 1);
                    ovf_pend_d = (64'(bin) > MAXV);
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d = work_sh;
                bin_d  = bin_sh;
                if (cnt_q == '0) begin
                    // Result is published on the same edge as the last shift.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    ovf_d   = ovf_pend_q;
                    bcd_d   = ovf_pend_q ? NINES : work_sh;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign bcd   = bcd_q;

endmodule
